// File: rtl/pt_check.sv
// Plaintext acceptance checker: scans a length-prefixed message in pt_mem and
// reports whether every message byte is printable, plus the first bad address.
module pt_check #(
  parameter logic [7:0] LO_CHAR = 8'h20,
  parameter logic [7:0] HI_CHAR = 8'h7E
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  output logic       rdy,
  output logic [7:0] pt_addr,
  input  logic [7:0] pt_rddata,
  output logic       valid,
  output logic [7:0] bad_addr,
  output logic [1:0] state
);

  // Handshake: a scan starts on any rising edge where en=1 and rdy=1; en while
  // rdy=0 is dropped. Results are stable whenever rdy=1.
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_CHECK = 2'd2
  } state_t;

  state_t     cur;
  state_t     nxt;
  logic [7:0] idx;
  logic [7:0] len;
  logic       in_range;

  assign in_range = (pt_rddata >= LO_CHAR) && (pt_rddata <= HI_CHAR);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cur <= S_IDLE;
    end else begin
      cur <= nxt;
    end
  end

  always_comb begin
    nxt = cur;
    case (cur)
      S_IDLE: begin
        if (en) begin
          nxt = S_READ;
        end
      end
      S_READ: begin
        nxt = S_CHECK;
      end
      S_CHECK: begin
        if (idx == 8'd0) begin
          nxt = (pt_rddata == 8'd0) ? S_IDLE : S_READ;
        end else if (!in_range || (idx == len)) begin
          nxt = S_IDLE;
        end else begin
          nxt = S_READ;
        end
      end
      default: begin
        nxt = S_IDLE;
      end
    endcase
  end

  always_comb begin
    rdy   = (cur == S_IDLE);
    state = cur;
  end

  // idx+1 is only taken while idx < len <= 255, so the 8-bit increment never wraps.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pt_addr  <= 8'd0;
      valid    <= 1'b0;
      bad_addr <= 8'd0;
      idx      <= 8'd0;
      len      <= 8'd0;
    end else begin
      case (cur)
        S_IDLE: begin
          if (en) begin
            pt_addr  <= 8'd0;
            valid    <= 1'b0;
            bad_addr <= 8'd0;
            idx      <= 8'd0;
          end
        end
        S_CHECK: begin
          if (idx == 8'd0) begin
            len <= pt_rddata;
            if (pt_rddata == 8'd0) begin
              valid <= 1'b1;
            end else begin
              pt_addr <= 8'd1;
              idx     <= 8'd1;
            end
          end else if (!in_range) begin
            valid    <= 1'b0;
            bad_addr <= idx;
          end else if (idx == len) begin
            valid <= 1'b1;
          end else begin
            pt_addr <= idx + 8'd1;
            idx     <= idx + 8'd1;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pt_check.sv
// Bench for pt_check: a synchronous-read RAM model, directed and random
// messages, and a reference scan computed directly from the message contents.
module tb_pt_check;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic       rdy;
  logic [7:0] pt_addr;
  logic [7:0] pt_rddata;
  logic       valid;
  logic [7:0] bad_addr;
  logic [1:0] state;

  int checks = 0;
  int failures = 0;

  logic [7:0] mem [256];
  logic [7:0] exp_q[$];

  pt_check dut (
    .clk(clk),
    .rst_n(rst_n),
    .en(en),
    .rdy(rdy),
    .pt_addr(pt_addr),
    .pt_rddata(pt_rddata),
    .valid(valid),
    .bad_addr(bad_addr),
    .state(state)
  );

  // clock / RAM model
  always #5 clk = ~clk;

  always @(posedge clk) pt_rddata <= mem[pt_addr];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Fill memory with junk, then place n bytes (MSB-first in v) from address 0.
  task automatic load(input int n, input logic [63:0] v);
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    for (int i = 0; i < n; i++) mem[i] = v[8*(n-1-i) +: 8];
  endtask

  // Reference: walk the message, stop at the first unprintable byte.
  function automatic void model(output logic ev, output logic [7:0] eb, output int n);
    int l;
    l  = int'(mem[0]);
    ev = 1'b1;
    eb = 8'd0;
    n  = l + 1;
    for (int a = 1; a <= l; a++) begin
      if (mem[a] < 8'h20 || mem[a] > 8'h7E) begin
        ev = 1'b0;
        eb = 8'(a);
        n  = a + 1;
        break;
      end
    end
  endfunction

  // Drive one scan; mid_en pulses en once while busy.
  task automatic run_scan(input string tag, input bit mid_en);
    logic       ev;
    logic [7:0] eb;
    logic [7:0] last;
    int         n;
    int         edges;
    int         seen;
    int         en_at;
    model(ev, eb, n);
    exp_q.delete();
    for (int a = 0; a < n; a++) exp_q.push_back(8'(a));
    en_at = (mid_en && n >= 2) ? int'($urandom_range(1, 2*n-2)) : -1;
    @(negedge clk);
    en = 1'b1;
    @(posedge clk);
    #1 en = 1'b0;
    edges = 0;
    seen  = 0;
    last  = 8'd0;
    while (!rdy && edges < 600) begin
      if (seen == 0 || pt_addr != last) begin
        seen++;
        if (exp_q.size() > 0) check({tag, "_addr"}, pt_addr, exp_q.pop_front());
      end
      last = pt_addr;
      @(posedge clk);
      #1 edges++;
      en = (edges == en_at);
    end
    en = 1'b0;
    check({tag, "_rdy"}, rdy, 1'b1);
    check({tag, "_edges"}, edges, 2*n);
    check({tag, "_addr_count"}, seen, n);
    check({tag, "_valid"}, valid, ev);
    check({tag, "_bad_addr"}, bad_addr, eb);
  endtask

  initial begin
    int l;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;

    // reset with en held high: nothing may start
    rst_n = 1'b0;
    en    = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_rdy", rdy, 1'b1);
    check("rst_addr", pt_addr, 8'd0);
    check("rst_valid", valid, 1'b0);
    check("rst_bad", bad_addr, 8'd0);
    en = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1 check("rst_idle_after_release", rdy, 1'b1);

    load(6, 64'h05_68_65_6c_6c_6f);  run_scan("hello", 1'b0);
    load(1, 64'h00);                 run_scan("empty", 1'b0);
    load(7, 64'h06_41_42_0A_43_44_45); run_scan("early", 1'b0);
    load(3, 64'h02_20_7E);           run_scan("bnd_edges", 1'b0);
    load(2, 64'h01_1F);              run_scan("bnd_1f", 1'b0);
    load(3, 64'h02_41_7F);           run_scan("bnd_7f", 1'b0);
    load(2, 64'h01_80);              run_scan("bnd_80", 1'b0);
    load(6, 64'h05_68_65_6c_6c_6f);  run_scan("hello_mid_en", 1'b1);

    for (int i = 0; i < 256; i++) mem[i] = 8'h41;
    mem[0] = 8'hFF;
    run_scan("len255", 1'b0);

    // reset mid-scan while reading address 3
    load(6, 64'h05_68_65_6c_6c_6f);
    @(negedge clk);
    en = 1'b1;
    @(posedge clk);
    #1 en = 1'b0;
    for (int c = 0; c < 40 && pt_addr != 8'd3; c++) begin
      @(posedge clk);
      #1;
    end
    check("midrst_reached_3", pt_addr, 8'd3);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check("midrst_rdy", rdy, 1'b1);
    check("midrst_valid", valid, 1'b0);
    check("midrst_addr", pt_addr, 8'd0);
    check("midrst_bad", bad_addr, 8'd0);
    rst_n = 1'b1;
    run_scan("after_rst", 1'b0);

    // random messages, mostly printable with occasional rejects
    for (int t = 0; t < 24; t++) begin
      for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
      l = (t % 6 == 5) ? int'($urandom_range(0, 255)) : int'($urandom_range(0, 40));
      mem[0] = 8'(l);
      for (int a = 1; a <= l; a++) begin
        mem[a] = ($urandom_range(0, 29) == 0) ? 8'($urandom) : 8'($urandom_range(32, 126));
      end
      run_scan($sformatf("rand%0d", t), bit'($urandom_range(0, 1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
